sram_ctrl: RTL
==============

# sram_ctrl

Wishbone classic slave that bridges the LM32 32-bit data/instruction bus to the board's 16-bit asynchronous SRAM. Each 32-bit access is split into two sequential half-word SRAM cycles, with programmable access time and fully registered SRAM control pins. The block sits inside the SoC between the bus arbiter and the SRAM pad pins. Its `sram_*` outputs are the signals exported to the top level as `sramsram_*`.

## Interface
- WAIT_CYCLES, 2: SRAM access/strobe width in clk_i cycles, legal range 1..15.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  byte address; only [20:2] are used.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_sel_i  in  4  byte selects; [3] selects bits 31:24.
- wb_we_i  in  1  1=write.
- wb_cyc_i, wb_stb_i  in  1 each  bus cycle / strobe.
- wb_ack_o  out  1  one-cycle transfer acknowledge.
- sram_csn  out  1  chip enable, active low.
- sram_oen  out  1  output enable, active low.
- sram_wen  out  1  write enable, active low.
- sram_be  out  2  {UB,LB} byte enables, active low.
- sram_addr  out  20  half-word address.
- sram_data  inout  16  data bus; tri-stated unless writing.

## Operation
- Big-endian mapping:
  - Half 0: sram_addr={adr[20:2],0}, carries data[31:16], sel[3:2].
  - Half 1: sram_addr={adr[20:2],1}, carries data[15:0], sel[1:0].
  - Within a half, UB maps to the upper byte.
- States: IDLE, RD (per half), WR_SETUP, WR_PULSE, WR_HOLD (per half), ACK.
- IDLE: request accepted when wb_cyc_i & wb_stb_i & !wb_ack_o. Address, data, sel and we are latched at acceptance.
- Read:
  - Both halves are always accessed.
  - sram_be=2'b00 and sram_oen=0 throughout.
  - Each half stays in RD for WAIT_CYCLES cycles.
  - sram_data is sampled into the wb_dat_o half on the last cycle of each phase.
- Write:
  - A half is skipped entirely if both of its sel bits are 0.
  - Per half: WR_SETUP for 1 cycle (addr/data driven, csn=0, wen=1), then WR_PULSE for WAIT_CYCLES cycles (wen=0), then WR_HOLD for 1 cycle (wen=1, addr/data held).
  - sram_be = ~sel pair.
  - If wb_sel_i=0 on a write, go straight to ACK with no SRAM activity.
- ACK:
  - wb_ack_o=1 for exactly one cycle.
  - csn/oen/wen=1 and sram_data released in the same cycle.
  - Returns to IDLE; a new request cannot be accepted until the cycle after ACK.
- All SRAM pins and the tri-state enable are driven from flops; no combinational path from wb_* to sram_*.
- Master drops wb_cyc_i mid-transfer:
  - The current half phase completes, including WR_HOLD.
  - The block then returns to IDLE without asserting ack.
  - wen is never cut short.
- rst_i, including mid-transfer: next edge forces IDLE with all reset values below. Partial writes are not rolled back.

## Timing
- Reset values:
  - sram_csn=1, sram_oen=1, sram_wen=1, sram_be=2'b11, sram_addr=0.
  - sram_data Hi-Z.
  - wb_ack_o=0, wb_dat_o=0.
- Cycle 0 is the cycle in which the request is accepted. SRAM outputs change from cycle 1.
- Read: half 0 occupies cycles 1..W, half 1 occupies W+1..2W, ack in cycle 2W+1. For W=2, ack is in cycle 5.
- Full write (both halves): ack in cycle 2(W+2)+1. For W=2, ack is in cycle 9.
- One-half write: ack in cycle W+3. For W=2, ack is in cycle 5.
- sram_addr and sram_data are stable at least 1 cycle before the wen falling edge and 1 cycle after its rising edge.
- Bus turnaround:
  - The data driver is released in the ACK cycle.
  - The earliest oen=0 of the next access is 2 cycles later, so there is no contention.
- Back-to-back requests: accepted every 2W+2 cycles for reads and 2W+6 cycles for full writes.

## Test plan
- Read, W=2: SRAM model holds 0x1234 at half addr 0x00010 and 0xABCD at 0x00011; read adr=0x20. Expect ack in cycle 5, wb_dat_o=0x1234ABCD, oen low in cycles 1-4, be=00.
- Full write: adr=0x40, dat=0xDEADBEEF, sel=1111. Expect 0xDEAD at 0x00020 and 0xBEEF at 0x00021, ack in cycle 9, wen low for exactly 2 cycles per half with addr/data stable around each pulse.
- Byte write: sel=0010, dat=0x0000AB00. Expect only half 1 accessed, be=2'b01 (UB active), only the upper byte changes, ack in cycle 5.
- sel=0000 write: expect ack in cycle 1, csn stays 1 throughout.
- Reset asserted in WR_PULSE: expect next cycle wen=1, csn=1, data Hi-Z, no ack; a subsequent read succeeds.
- W=1 back-to-back read, write, read with cyc held high: expect no cycle where oen=0 while sram_data is driven; each ack is exactly one cycle wide.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: Wishbone classic bus between the bus arbiter and sram_ctrl
interface sram_ctrl_if;
  logic        cyc, stb, we, ack;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  modport master (output cyc, stb, we, adr, wdat, sel, input ack, rdat);
  modport slave  (input cyc, stb, we, adr, wdat, sel, output ack, rdat);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: Wishbone slave splitting 32-bit accesses into two 16-bit async SRAM cycles
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  sram_ctrl_if.slave  wb,
  output logic        sram_csn,
  output logic        sram_oen,
  output logic        sram_wen,
  output logic [1:0]  sram_be,
  output logic [19:0] sram_addr,
  inout  wire  [15:0] sram_data
);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK} state_t;
  state_t state;
  logic half, drive, ack, last, first_half, unused;
  logic [3:0] cnt;
  logic [1:0] sel_lo;
  logic [18:0] adr;
  logic [15:0] wlo, dout;
  logic [31:0] rdat;
  assign last = cnt == 4'(WAIT_CYCLES - 1);
  // writes with no upper-half selects skip straight to half 1
  assign first_half = wb.we && wb.sel[3:2] == 2'b00;
  assign sram_data = drive ? dout : 16'hzzzz;
  assign wb.ack = ack;
  assign wb.rdat = rdat;
  assign unused = ^{wb.adr[31:21], wb.adr[1:0]};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      half <= 1'b0;
      cnt <= '0;
      sel_lo <= '0;
      adr <= '0;
      wlo <= '0;
      dout <= '0;
      rdat <= '0;
      ack <= 1'b0;
      drive <= 1'b0;
      sram_csn <= 1'b1;
      sram_oen <= 1'b1;
      sram_wen <= 1'b1;
      sram_be <= 2'b11;
      sram_addr <= '0;
    end else begin
      case (state)
        IDLE: if (wb.cyc && wb.stb && !ack) begin
          adr <= wb.adr[20:2];
          wlo <= wb.wdat[15:0];
          sel_lo <= wb.sel[1:0];
          cnt <= '0;
          half <= first_half;
          if (wb.we && wb.sel == 4'b0000) begin
            state <= ACK;
            ack <= 1'b1;
          end else begin
            state <= wb.we ? WR_SETUP : RD;
            sram_csn <= 1'b0;
            sram_oen <= wb.we;
            drive <= wb.we;
            sram_addr <= {wb.adr[20:2], first_half};
            dout <= first_half ? wb.wdat[15:0] : wb.wdat[31:16];
            sram_be <= !wb.we ? 2'b00 : first_half ? ~wb.sel[1:0] : ~wb.sel[3:2];
          end
        end
        RD: if (last) begin
          cnt <= '0;
          if (half) rdat[15:0] <= sram_data;
          else rdat[31:16] <= sram_data;
          if (!wb.cyc || half) begin
            state <= wb.cyc ? ACK : IDLE;
            ack <= wb.cyc;
            sram_csn <= 1'b1;
            sram_oen <= 1'b1;
            sram_be <= 2'b11;
          end else begin
            half <= 1'b1;
            sram_addr <= {adr, 1'b1};
          end
        end else cnt <= cnt + 4'd1;
        WR_SETUP: begin
          state <= WR_PULSE;
          sram_wen <= 1'b0;
        end
        WR_PULSE: if (last) begin
          cnt <= '0;
          state <= WR_HOLD;
          sram_wen <= 1'b1;
        end else cnt <= cnt + 4'd1;
        WR_HOLD: if (wb.cyc && !half && sel_lo != 2'b00) begin
          state <= WR_SETUP;
          half <= 1'b1;
          sram_addr <= {adr, 1'b1};
          dout <= wlo;
          sram_be <= ~sel_lo;
        end else begin
          state <= wb.cyc ? ACK : IDLE;
          ack <= wb.cyc;
          sram_csn <= 1'b1;
          drive <= 1'b0;
          sram_be <= 2'b11;
        end
        ACK: begin
          state <= IDLE;
          ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
